// File: rtl/mbus_slave_mem.sv
// MBUS slave memory: SINGLE/BURST4/BURST8 transfers against a word array, full per-beat response set.
// Latency: MRDY one cycle after a request plus WAIT_STATES; MRESP/MRDATA one cycle after each accepting edge.
// Backpressure: MRDY low during wait cycles and for at least one cycle after the last beat of a burst.
module mbus_slave_mem #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                DEPTH       = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                WAIT_STATES = 0,
    parameter int                INIT_TRACK  = 1
) (
    input  logic              MCLK,
    input  logic              MRESET,
    input  logic [1:0]        MOPCODE,
    input  logic [ADDR_W-1:0] MADDR,
    input  logic              MREAD,
    input  logic [DATA_W-1:0] MWDATA,
    output logic              MRDY,
    output logic [2:0]        MRESP,
    output logic [DATA_W-1:0] MRDATA,
    output logic              MPROTO_ERR
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int WIN_W = ADDR_W + 1;

    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BYTES - 1);
    localparam logic [WIN_W-1:0]  WIN_SIZE   = WIN_W'(DEPTH * BYTES);
    localparam logic [3:0]        WLOAD      = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    localparam logic [1:0] OP_IDLE   = 2'd0;
    localparam logic [1:0] OP_SINGLE = 2'd1;
    localparam logic [1:0] OP_BURST4 = 2'd2;
    localparam logic [1:0] OP_BURST8 = 2'd3;

    localparam logic [2:0] RSP_NULL           = 3'd0;
    localparam logic [2:0] RSP_READ_VALID     = 3'd1;
    localparam logic [2:0] RSP_READ_ADDR_ERR  = 3'd2;
    localparam logic [2:0] RSP_READ_UNINIT    = 3'd3;
    localparam logic [2:0] RSP_WRITE_COMPLETE = 3'd4;
    localparam logic [2:0] RSP_WRITE_ADDR_ERR = 3'd5;
    localparam logic [2:0] RSP_ADDR_ERR       = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_BEAT
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        wcnt;
    logic [3:0]        wcnt_nxt;
    logic [1:0]        op_q;
    logic [3:0]        rem_q;
    logic              first_q;
    logic [ADDR_W-1:0] addr_q;
    logic              read_q;
    logic              viol_q;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  written;

    logic              start;
    logic              accept;
    logic              last;
    logic              viol;
    logic [ADDR_W-1:0] beat_addr;
    logic              beat_read;
    logic [ADDR_W-1:0] off;
    logic              aligned;
    logic              in_win;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] stored;
    logic              wr_en;
    logic [2:0]        resp_nxt;
    logic [DATA_W-1:0] rdata_nxt;

    function automatic logic [3:0] beat_count(input logic [1:0] op);
        case (op)
            OP_SINGLE: return 4'd1;
            OP_BURST4: return 4'd4;
            OP_BURST8: return 4'd8;
            default:   return 4'd0;
        endcase
    endfunction

    assign last = (rem_q == 4'd1);

    always_ff @(posedge MCLK) begin
        if (MRESET) begin
            state <= ST_IDLE;
            wcnt  <= 4'd0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    // A beat is only taken while the master keeps a non-IDLE opcode; an
    // abandoned burst simply parks in BEAT until the master returns.
    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        start     = 1'b0;
        accept    = 1'b0;
        viol      = (state != ST_IDLE) && (MOPCODE != op_q);
        case (state)
            ST_IDLE: begin
                if (MOPCODE != OP_IDLE) begin
                    start     = 1'b1;
                    wcnt_nxt  = WLOAD;
                    state_nxt = (WAIT_STATES > 0) ? ST_WAIT : ST_BEAT;
                end
            end
            ST_WAIT: begin
                if (wcnt == 4'd0) begin
                    state_nxt = ST_BEAT;
                end else begin
                    wcnt_nxt = wcnt - 4'd1;
                end
            end
            ST_BEAT: begin
                if (MOPCODE != OP_IDLE) begin
                    accept = 1'b1;
                    if (last) begin
                        state_nxt = ST_IDLE;
                    end else if (WAIT_STATES > 0) begin
                        state_nxt = ST_WAIT;
                        wcnt_nxt  = WLOAD;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Beat 0 takes address and direction straight from the bus; later beats
    // use the incremented copy. The window offset is modulo ADDR_W, so any
    // address below BASE_ADDR wraps to a huge offset and fails the range test.
    always_comb begin
        beat_addr = first_q ? MADDR : addr_q;
        beat_read = first_q ? MREAD : read_q;
        off       = beat_addr - BASE_ADDR;
        aligned   = ((beat_addr & ALIGN_MASK) == '0);
        in_win    = ({1'b0, off} < WIN_SIZE);
        idx       = IDX_W'(off >> OFF_W);
        stored    = written[idx] ? mem[idx] : '0;
        resp_nxt  = RSP_NULL;
        rdata_nxt = '0;
        wr_en     = 1'b0;
        if (!aligned) begin
            resp_nxt = RSP_ADDR_ERR;
        end else if (!in_win) begin
            resp_nxt = beat_read ? RSP_READ_ADDR_ERR : RSP_WRITE_ADDR_ERR;
        end else if (!beat_read) begin
            resp_nxt = RSP_WRITE_COMPLETE;
            wr_en    = accept;
        end else if ((INIT_TRACK != 0) && !written[idx]) begin
            resp_nxt = RSP_READ_UNINIT;
        end else begin
            resp_nxt  = RSP_READ_VALID;
            rdata_nxt = stored;
        end
    end

    always_ff @(posedge MCLK) begin
        if (MRESET) begin
            MRDY       <= 1'b0;
            MRESP      <= RSP_NULL;
            MRDATA     <= '0;
            MPROTO_ERR <= 1'b0;
            viol_q     <= 1'b0;
            op_q       <= OP_IDLE;
            rem_q      <= 4'd0;
            first_q    <= 1'b0;
            addr_q     <= '0;
            read_q     <= 1'b0;
            written    <= '0;
        end else begin
            MRDY       <= (state_nxt == ST_BEAT);
            viol_q     <= viol;
            MPROTO_ERR <= viol && !viol_q;
            MRESP      <= RSP_NULL;
            MRDATA     <= '0;
            if (start) begin
                op_q    <= MOPCODE;
                rem_q   <= beat_count(MOPCODE);
                first_q <= 1'b1;
            end
            if (accept) begin
                rem_q   <= rem_q - 4'd1;
                first_q <= 1'b0;
                addr_q  <= beat_addr + STEP;
                read_q  <= beat_read;
                MRESP   <= resp_nxt;
                MRDATA  <= rdata_nxt;
                if (wr_en) begin
                    written[idx] <= 1'b1;
                end
            end
        end
    end

    // Array has no reset; a beat landing on a reset edge is dropped.
    always_ff @(posedge MCLK) begin
        if (wr_en && !MRESET) begin
            mem[idx] <= MWDATA;
        end
    end

endmodule

// File: tb/tb_mbus_slave_mem.sv
// Bench for mbus_slave_mem: two instances (no wait states at base 0, two wait states at base 0x1000)
// driven from a shared bus and checked against an associative-array memory model.
module tb_mbus_slave_mem;

    logic        MCLK = 1'b0;
    logic        MRESET;
    logic [1:0]  MOPCODE;
    logic [31:0] MADDR;
    logic        MREAD;
    logic [31:0] MWDATA;

    logic        rdy0, rdy1, perr0, perr1;
    logic [2:0]  resp0, resp1;
    logic [31:0] rdat0, rdat1;

    logic        sel = 1'b0;
    logic        rdy_s, perr_s;
    logic [2:0]  resp_s;
    logic [31:0] rdat_s;

    assign rdy_s  = sel ? rdy1  : rdy0;
    assign perr_s = sel ? perr1 : perr0;
    assign resp_s = sel ? resp1 : resp0;
    assign rdat_s = sel ? rdat1 : rdat0;

    int checks   = 0;
    int errors   = 0;
    int edge_cnt = 0;
    int e0;
    int pulses;
    int rdy_hi;
    int acc_edges [8];
    logic [31:0] wd [8];
    logic [31:0] mdl [longint];

    mbus_slave_mem #(.WAIT_STATES(0)) dut0 (
        .MCLK(MCLK), .MRESET(MRESET), .MOPCODE(MOPCODE), .MADDR(MADDR), .MREAD(MREAD),
        .MWDATA(MWDATA), .MRDY(rdy0), .MRESP(resp0), .MRDATA(rdat0), .MPROTO_ERR(perr0)
    );

    mbus_slave_mem #(.BASE_ADDR(32'h1000), .WAIT_STATES(2)) dut1 (
        .MCLK(MCLK), .MRESET(MRESET), .MOPCODE(MOPCODE), .MADDR(MADDR), .MREAD(MREAD),
        .MWDATA(MWDATA), .MRDY(rdy1), .MRESP(resp1), .MRDATA(rdat1), .MPROTO_ERR(perr1)
    );

    always #5 MCLK = ~MCLK;
    always @(posedge MCLK) edge_cnt <= edge_cnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Memory model: window of 256 words from base, written words live in mdl.
    function automatic void model_beat(input logic s, input logic [31:0] a, input logic rd,
                                       input logic [31:0] wdat, output logic [2:0] r,
                                       output logic [31:0] d);
        longint base;
        longint ua;
        longint key;
        base = s ? 64'h1000 : 64'h0;
        ua   = {32'b0, a};
        key  = {31'b0, s, a};
        d    = 32'd0;
        if (a[1:0] != 2'b00) r = 3'd6;
        else if (ua < base || ua >= base + 1024) r = rd ? 3'd2 : 3'd5;
        else if (!rd) begin
            mdl[key] = wdat;
            r = 3'd4;
        end else if (mdl.exists(key)) begin
            r = 3'd1;
            d = mdl[key];
        end else r = 3'd3;
    endfunction

    task automatic xfer(input logic [1:0] op, input logic [31:0] addr, input logic rd,
                        input logic [1:0] alt);
        int n, k, cyc, exp_p;
        logic pend;
        logic [2:0] er;
        logic [31:0] ed;
        n = (op == 2'd1) ? 1 : (op == 2'd2) ? 4 : 8;
        k = 0; cyc = 0; pend = 1'b0; pulses = 0; rdy_hi = 0; er = 3'd0; ed = 32'd0;
        MOPCODE = op; MADDR = addr; MREAD = rd; MWDATA = wd[0];
        e0 = edge_cnt + 1;
        while ((k < n || pend) && cyc < 200) begin
            @(negedge MCLK);
            cyc++;
            checks++;
            if (pend) begin
                if (resp_s !== er || rdat_s !== ed) begin
                    errors++;
                    $display("FAIL resp beat %0d addr %0h: got %0d/%0h expected %0d/%0h",
                             k - 1, addr + 32'((k - 1) * 4), resp_s, rdat_s, er, ed);
                end
                pend = 1'b0;
            end else if (resp_s !== 3'd0 || rdat_s !== 32'd0) begin
                errors++;
                $display("FAIL idle_resp: got %0d/%0h expected 0/0", resp_s, rdat_s);
            end
            if (perr_s === 1'b1) pulses++;
            if (rdy_s === 1'b1) rdy_hi++;
            if (k == n) begin
                MOPCODE = 2'd0;
                checks++;
                if (rdy_s !== 1'b0) begin
                    errors++;
                    $display("FAIL rdy_after_last: got %b expected 0", rdy_s);
                end
            end else begin
                if (k > 0) MOPCODE = alt;
                MWDATA = wd[k];
                if (rdy_s === 1'b1) begin
                    model_beat(sel, addr + 32'(k * 4), rd, wd[k], er, ed);
                    acc_edges[k] = edge_cnt + 1 - e0;
                    pend = 1'b1;
                    k++;
                end
            end
        end
        MOPCODE = 2'd0;
        checks++;
        if (k < n || pend) begin
            errors++;
            $display("FAIL xfer_timeout: beats %0d expected %0d", k, n);
        end
        exp_p = (alt != op && n > 1) ? 1 : 0;
        checks++;
        if (pulses != exp_p) begin
            errors++;
            $display("FAIL proto_pulses: got %0d expected %0d", pulses, exp_p);
        end
        checks++;
        if (rdy_hi != n) begin
            errors++;
            $display("FAIL rdy_cycles: got %0d expected %0d", rdy_hi, n);
        end
    endtask

    task automatic test_reset();
        MRESET = 1'b1; MOPCODE = 2'd0; MADDR = 32'd0; MREAD = 1'b0; MWDATA = 32'd0;
        repeat (3) @(negedge MCLK);
        checks++; if (rdy_s !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b expected 0", rdy_s); end
        checks++; if (resp_s !== 3'd0) begin errors++; $display("FAIL reset_resp: got %0d expected 0", resp_s); end
        checks++; if (rdat_s !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %0h expected 0", rdat_s); end
        checks++; if (perr_s !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b expected 0", perr_s); end
        MRESET = 1'b0;
        mdl.delete();
        @(negedge MCLK);
    endtask

    task automatic test_uninit();
        xfer(2'd1, 32'h10, 1'b1, 2'd1);
        checks++;
        if (acc_edges[0] != 1) begin
            errors++;
            $display("FAIL first_accept_edge: got %0d expected 1", acc_edges[0]);
        end
    endtask

    task automatic test_write_read();
        wd[0] = 32'hDEADBEEF;
        xfer(2'd1, 32'h10, 1'b0, 2'd1);
        xfer(2'd1, 32'h10, 1'b1, 2'd1);
    endtask

    task automatic test_burst_cross();
        for (int i = 0; i < 8; i++) wd[i] = $urandom;
        xfer(2'd3, 32'h3F0, 1'b0, 2'd3);
        xfer(2'd2, 32'h3F0, 1'b1, 2'd2);
    endtask

    task automatic test_misaligned();
        xfer(2'd1, 32'h2, 1'b1, 2'd1);
        xfer(2'd2, 32'h6, 1'b0, 2'd2);
        xfer(2'd2, 32'h4, 1'b1, 2'd2);
    endtask

    task automatic test_proto();
        xfer(2'd2, 32'h3F0, 1'b1, 2'd1);
    endtask

    task automatic test_back_to_back();
        int a0, a1, a2;
        wd[0] = 32'h1111_0001; xfer(2'd1, 32'h20, 1'b0, 2'd1); a0 = e0 + acc_edges[0];
        wd[0] = 32'h2222_0002; xfer(2'd1, 32'h24, 1'b0, 2'd1); a1 = e0 + acc_edges[0];
        wd[0] = 32'h3333_0003; xfer(2'd1, 32'h28, 1'b0, 2'd1); a2 = e0 + acc_edges[0];
        checks++; if (a1 - a0 != 2) begin errors++; $display("FAIL b2b_gap1: got %0d expected 2", a1 - a0); end
        checks++; if (a2 - a1 != 2) begin errors++; $display("FAIL b2b_gap2: got %0d expected 2", a2 - a1); end
        xfer(2'd1, 32'h24, 1'b1, 2'd1);
        xfer(2'd2, 32'h20, 1'b1, 2'd2);
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] a;
        for (int t = 0; t < 30; t++) begin
            op = 2'($urandom_range(1, 3));
            a  = 32'($urandom_range(0, 32'h41F));
            if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
            for (int i = 0; i < 8; i++) wd[i] = $urandom;
            xfer(op, a, 1'($urandom_range(0, 1)), op);
        end
    endtask

    task automatic test_reset_mid();
        int k, cyc;
        logic hit;
        k = 0; cyc = 0; hit = 1'b0;
        MOPCODE = 2'd3; MADDR = 32'h100; MREAD = 1'b0;
        while (cyc < 100) begin
            @(negedge MCLK);
            cyc++;
            MWDATA = $urandom;
            if (rdy_s === 1'b1) begin
                if (k == 2) begin
                    MRESET = 1'b1;
                    hit = 1'b1;
                    break;
                end
                k++;
            end
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL reset_mid_timeout: beats %0d expected 2", k); end
        @(negedge MCLK);
        checks++; if (rdy_s !== 1'b0) begin errors++; $display("FAIL reset_mid_rdy: got %b expected 0", rdy_s); end
        checks++; if (resp_s !== 3'd0) begin errors++; $display("FAIL reset_mid_resp: got %0d expected 0", resp_s); end
        MRESET = 1'b0; MOPCODE = 2'd0;
        mdl.delete();
        xfer(2'd1, 32'h100, 1'b1, 2'd1);
    endtask

    task automatic test_wait_states();
        xfer(2'd1, 32'h0FFC, 1'b1, 2'd1);
        for (int i = 0; i < 8; i++) wd[i] = $urandom;
        xfer(2'd2, 32'h1000, 1'b0, 2'd2);
        xfer(2'd2, 32'h1000, 1'b1, 2'd2);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (acc_edges[i] != 3 * (i + 1)) begin
                errors++;
                $display("FAIL wait_accept_edge %0d: got %0d expected %0d", i, acc_edges[i], 3 * (i + 1));
            end
        end
        for (int i = 0; i < 8; i++) wd[i] = $urandom;
        xfer(2'd3, 32'h13F0, 1'b0, 2'd3);
        xfer(2'd3, 32'h13F0, 1'b1, 2'd3);
    endtask

    initial begin
        sel = 1'b0;
        test_reset();
        test_uninit();
        test_write_read();
        test_burst_cross();
        test_misaligned();
        test_proto();
        test_back_to_back();
        test_random();
        test_reset_mid();
        sel = 1'b1;
        test_reset();
        test_wait_states();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mbus_slave_mem.md
# mbus_slave_mem

Parametrised MBUS slave memory. It replaces fixed-width slave models with one RTL block that has configurable address/data width, depth, address window and wait states. It executes SINGLE, BURST4 and BURST8 transfers against an internal word array. Per beat, it returns the full MBUS response set: READ_VALID, READ_ADDR_ERROR, READ_UNINIT, WRITE_COMPLETE, WRITE_ADDR_ERROR or ADDR_ERROR. It sits on the slave side of the MBUS interface and is the DUT-side counterpart of the pipelined get/put slave agent.

## Interface
Clock and reset: one clock; reset is synchronous and active-high.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, data width; must be 8·2^n, n ≥ 0.
- DEPTH, 256, number of DATA_W words; power of two.
- BASE_ADDR, 0, byte base of the window; aligned to DEPTH·DATA_W/8.
- WAIT_STATES, 0, MRDY-low cycles inserted before every beat (0–15).
- INIT_TRACK, 1, 1 = per-word written flag enables READ_UNINIT; 0 = unwritten words read as 0 with READ_VALID.

Ports:
- MCLK, in, 1, clock.
- MRESET, in, 1, synchronous active-high reset.
- MOPCODE, in, 2, 0 IDLE, 1 SINGLE, 2 BURST4, 3 BURST8.
- MADDR, in, ADDR_W, byte address; sampled on first beat only.
- MREAD, in, 1, 1 read / 0 write; sampled on first beat only.
- MWDATA, in, DATA_W, write data; sampled every write beat.
- MRDY, out, 1, slave ready; a beat transfers on a rising MCLK edge with MRDY=1 and MOPCODE≠IDLE.
- MRESP, out, 3, response code, one per beat; NULL (0) when no response.
- MRDATA, out, DATA_W, read data; 0 unless MRESP=READ_VALID.
- MPROTO_ERR, out, 1, one-cycle pulse on protocol violation.

## Operation
- FSM states: IDLE, WAIT, BEAT.
- IDLE→WAIT when MOPCODE≠IDLE and WAIT_STATES>0. IDLE→BEAT when MOPCODE≠IDLE and WAIT_STATES=0.
- WAIT: an internal counter loads WAIT_STATES−1 and counts down. At 0 the FSM moves to BEAT.
- BEAT: MRDY=1. Each accepted beat decrements the beat counter.
  - Last beat accepted → IDLE.
  - Otherwise → WAIT if WAIT_STATES>0, else stay in BEAT.
- First beat latches opcode, MREAD and MADDR. Beat count is 1, 4 or 8.
- Beat address is latched MADDR + k·(DATA_W/8) for k = 0..count−1. Addition is ADDR_W-bit modulo.
- Per-beat checks, in priority order:
  - Beat address not aligned to DATA_W/8 → ADDR_ERROR. This applies to every beat of a misaligned burst.
  - Address outside [BASE_ADDR, BASE_ADDR+DEPTH·DATA_W/8) → READ_ADDR_ERROR or WRITE_ADDR_ERROR. A burst that crosses the window end errors only the out-of-window beats. There is no wrap into the window.
  - Write: store MWDATA, set the word's written flag, respond WRITE_COMPLETE.
  - Read: if INIT_TRACK=1 and the flag is clear → READ_UNINIT with MRDATA=0. Else READ_VALID with the stored word.
- Errored writes do not modify the array or the flags.
- Protocol violations pulse MPROTO_ERR for one cycle. The burst still continues with the latched opcode.
  - MOPCODE differs from the latched opcode during a beat or wait cycle, including a drop to IDLE.
  - MOPCODE≠IDLE is accepted; an abandoned burst is not cancelled.
- Write then read of the same word: the read returns the new data, because the write beat completes before any later beat is accepted.

## Timing
- Reset values: MRDY=0, MRESP=NULL, MRDATA=0, MPROTO_ERR=0, FSM=IDLE, all written flags cleared. Array contents are undefined.
- Reset mid-burst aborts the burst immediately. No further responses are issued.
- MRDY is registered. With WAIT_STATES=0, a request seen at edge 0 gives MRDY=1 after edge 0, and beat 0 is accepted at edge 1.
- With WAIT_STATES=W, beat 0 is accepted at edge W+1.
- Burst beats are accepted every cycle when W=0, otherwise every W+1 cycles.
- Response latency: MRESP and MRDATA are registered and valid in the cycle after the accepting edge. They return to NULL/0 in the following cycle unless another beat was accepted.
- After the last beat, MRDY=0 for at least one cycle. The minimum back-to-back SINGLE rate is one transfer per 2 cycles.
- The array is read synchronously at the accepting edge. There is no read-during-write hazard, because only one beat is accepted per edge.

## Test plan
- Reset, then SINGLE read at BASE_ADDR+0x10 → READ_UNINIT, MRDATA=0, one cycle after acceptance.
- SINGLE write 0xDEADBEEF to 0x10, then SINGLE read of 0x10 → WRITE_COMPLETE, then READ_VALID with 0xDEADBEEF.
- DEPTH=256, DATA_W=32: BURST8 write at 0x3F0 → beats 0–3 WRITE_COMPLETE, beats 4–7 WRITE_ADDR_ERROR. Read-back of 0x3F0..0x3FC returns the data.
- WAIT_STATES=2, BURST4 read → MRDY high one cycle in every 3, 4 responses, accept edges at 3, 6, 9, 12.
- SINGLE read at 0x2 → ADDR_ERROR. MOPCODE changed from BURST4 to SINGLE mid-burst → MPROTO_ERR pulse and all 4 beats completed.
- Reset asserted during beat 2 of BURST8 write → MRDY=0 and MRESP=NULL next cycle. A subsequent read of beat 0's address → READ_UNINIT.
